// File: rtl/wb_traffic_pkg.sv
// wb_traffic_pkg: shared types and constants
// for the Wishbone traffic master.
package wb_traffic_pkg;

  localparam int ERRCNT_W = 16;

  localparam logic [1:0] MODE_INTERLEAVE = 2'd0;
  localparam logic [1:0] MODE_BLOCK      = 2'd1;
  localparam logic [1:0] MODE_WRITE      = 2'd2;
  localparam logic [1:0] MODE_READ       = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_GAP
  } state_t;

  function automatic logic [ERRCNT_W-1:0] sat_inc(
    input logic [ERRCNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_traffic_master_if.sv
// wb_traffic_master_if: Wishbone classic bus
// bundle with master and slave views.
interface wb_traffic_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;
  logic                  err_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i, err_i
  );

endinterface

// File: rtl/wb_pattern_gen.sv
// wb_pattern_gen: incremental address/data
// generator for the current word.
module wb_pattern_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] PATTERN_STEP =
    DATA_WIDTH'(32'h11111111)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  rewind,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] seed_q;

  // Word 0 on load/rewind, then add stride and step per word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seed_q <= '0;
      addr   <= '0;
      data   <= '0;
    end else if (load) begin
      seed_q <= seed;
      addr   <= ADDR_BASE;
      data   <= seed;
    end else if (rewind) begin
      addr <= ADDR_BASE;
      data <= seed_q;
    end else if (step) begin
      addr <= addr + ADDR_STRIDE;
      data <= data + PATTERN_STEP;
    end
  end

endmodule

// File: rtl/wb_traffic_master.sv
// wb_traffic_master: Wishbone classic traffic
// generator and read-back checker.
module wb_traffic_master
  import wb_traffic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_COUNT = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] PATTERN_STEP =
    DATA_WIDTH'(32'h11111111),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  wb_traffic_master_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic [ERRCNT_W-1:0]   error_count,
  output logic                  timeout
);

  localparam int IDX_W = $clog2(WORD_COUNT);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state;
  logic [1:0]            mode_q;
  logic                  op_we;
  logic [IDX_W-1:0]      idx;
  logic [TO_W-1:0]       tcnt;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [DATA_WIDTH-1:0] gen_data;

  logic last;
  logic pair;
  logic term;
  logic rd_bad;
  logic gen_load;
  logic gen_step;
  logic gen_rewind;

  assign last = idx == IDX_W'(WORD_COUNT - 1);
  assign pair = (mode_q == MODE_INTERLEAVE) && op_we;
  assign term = bus.stb_o && (bus.ack_i || bus.err_i);
  assign rd_bad = !op_we && bus.ack_i
    && (bus.dat_i != gen_data);

  assign gen_load = (state == S_IDLE) && start;
  assign gen_step = (state == S_GAP) && !pair && !last;
  assign gen_rewind = (state == S_GAP) && !pair && last
    && (mode_q == MODE_BLOCK) && op_we;

  wb_pattern_gen #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ADDR_BASE    (ADDR_BASE),
    .ADDR_STRIDE  (ADDR_STRIDE),
    .PATTERN_STEP (PATTERN_STEP)
  ) u_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (gen_load),
    .rewind (gen_rewind),
    .step   (gen_step),
    .seed   (seed),
    .addr   (gen_addr),
    .data   (gen_data)
  );

  // Run sequencer: request, wait for termination, one idle gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      mode_q      <= MODE_INTERLEAVE;
      op_we       <= 1'b0;
      idx         <= '0;
      tcnt        <= '0;
      bus.cyc_o   <= 1'b0;
      bus.stb_o   <= 1'b0;
      bus.we_o    <= 1'b0;
      bus.adr_o   <= '0;
      bus.dat_o   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error_count <= '0;
      timeout     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_q      <= mode;
            op_we       <= mode != MODE_READ;
            idx         <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            error_count <= '0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          bus.cyc_o <= 1'b1;
          bus.stb_o <= 1'b1;
          bus.we_o  <= op_we;
          bus.adr_o <= gen_addr;
          if (op_we) bus.dat_o <= gen_data;
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (term) begin
            bus.cyc_o <= 1'b0;
            bus.stb_o <= 1'b0;
            bus.we_o  <= 1'b0;
            if (bus.err_i || rd_bad)
              error_count <= sat_inc(error_count);
            state <= S_GAP;
          end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            bus.cyc_o <= 1'b0;
            bus.stb_o <= 1'b0;
            bus.we_o  <= 1'b0;
            timeout   <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (pair) begin
            op_we <= 1'b0;
            state <= S_REQ;
          end else if (!last) begin
            idx <= idx + 1'b1;
            if (mode_q == MODE_INTERLEAVE) op_we <= 1'b1;
            state <= S_REQ;
          end else if (mode_q == MODE_BLOCK && op_we) begin
            idx   <= '0;
            op_we <= 1'b0;
            state <= S_REQ;
          end else begin
            busy      <= 1'b0;
            done      <= 1'b1;
            bus.adr_o <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_traffic_master.sv
// tb_wb_traffic_master: randomized scoreboard
// bench with a RAM slave model.
module tb_wb_traffic_master;
  import wb_traffic_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int WC = 16;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] STRIDE = 32'd4;
  localparam logic [31:0] STEP = 32'h11111111;
  localparam int TMO = 10;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed = '0;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] error_count;

  wb_traffic_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  wb_traffic_master #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .WORD_COUNT     (WC),
    .ADDR_BASE      (BASE),
    .ADDR_STRIDE    (STRIDE),
    .PATTERN_STEP   (STEP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .seed        (seed),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error_count (error_count),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // RAM slave: random wait states, optional hang and error injection
  logic [31:0] mem [64];
  int   wcnt = 0;
  int   wtgt = 0;
  int   waits_max = 0;
  int   err_at = -1;
  int   tot_terms = 0;
  bit   hang = 1'b0;
  bit   pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;
  logic ready;

  assign ready = bus.stb_o && !hang && (wcnt >= wtgt);
  assign bus.ack_i = ready;
  assign bus.err_i = ready && (tot_terms == err_at);
  assign bus.dat_i = mem[bus.adr_o[7:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    if (ready) begin
      if (bus.we_o && !bus.err_i) mem[bus.adr_o[7:2]] <= bus.dat_o;
      tot_terms <= tot_terms + 1;
      wcnt <= 0;
      wtgt <= int'($urandom_range(waits_max, 0));
    end else if (bus.stb_o) begin
      wcnt <= wcnt + 1;
    end
  end

  // Monitor: pop expected transaction at each bus termination
  txn_t exp_q[$];
  bit   mon_en = 1'b1;

  always @(negedge clk) begin
    txn_t e;
    if (mon_en && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_txn: got adr %h want none", bus.adr_o);
      end else begin
        e = exp_q.pop_front();
        chk("txn_we", {31'd0, bus.we_o}, {31'd0, e.we});
        chk("txn_adr", bus.adr_o, e.adr);
        if (e.we) chk("txn_dat", bus.dat_o, e.dat);
      end
    end
  end

  function automatic logic [31:0] w_adr(input int i);
    return BASE + STRIDE * 32'(i);
  endfunction

  function automatic logic [31:0] w_dat(input logic [31:0] s,
                                        input int i);
    return s + STEP * 32'(i);
  endfunction

  // Reference model: transaction list and expected error count
  task automatic plan(input logic [1:0] m, input logic [31:0] s,
                      input int err_rel, output int nt, output int ne);
    txn_t l[$];
    logic [31:0] sh [WC];
    for (int i = 0; i < WC; i++) sh[i] = mem[i];
    for (int i = 0; i < WC; i++) begin
      if (m != MODE_READ) l.push_back({1'b1, w_adr(i), w_dat(s, i)});
      if (m == MODE_INTERLEAVE)
        l.push_back({1'b0, w_adr(i), w_dat(s, i)});
    end
    if (m == MODE_BLOCK || m == MODE_READ)
      for (int i = 0; i < WC; i++)
        l.push_back({1'b0, w_adr(i), w_dat(s, i)});
    ne = 0;
    for (int k = 0; k < l.size(); k++) begin
      int w;
      w = int'((l[k].adr - BASE) / STRIDE);
      if (k == err_rel) ne++;
      else if (l[k].we) sh[w] = l[k].dat;
      else if (sh[w] != l[k].dat) ne++;
      exp_q.push_back(l[k]);
    end
    nt = l.size();
  endtask

  task automatic run(input logic [1:0] m, input logic [31:0] s,
                     input int wmax, input int err_rel,
                     input string tag);
    int nt;
    int ne;
    int cyc;
    plan(m, s, err_rel, nt, ne);
    waits_max = wmax;
    err_at = (err_rel < 0) ? -1 : tot_terms + err_rel;
    @(negedge clk);
    mode = m;
    seed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_on"}, {31'd0, busy}, 1);
    chk({tag, "_done_clr"}, {31'd0, done}, 0);
    chk({tag, "_tmo_clr"}, {31'd0, timeout}, 0);
    chk({tag, "_err_clr"}, {16'd0, error_count}, 0);
    @(posedge clk);
    #1;
    cyc = 1;
    chk({tag, "_req_timing"}, {31'd0, bus.cyc_o}, 1);
    while (!done && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_done"}, {31'd0, done}, 1);
    if (wmax == 0) chk({tag, "_cycles"}, cyc, 3 * nt);
    chk({tag, "_errcnt"}, {16'd0, error_count}, ne);
    chk({tag, "_busy_off"}, {31'd0, busy}, 0);
    chk({tag, "_tmo"}, {31'd0, timeout}, 0);
    chk({tag, "_adr_idle"}, bus.adr_o, 0);
    chk({tag, "_q_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic poke(input int i, input logic [31:0] d);
    @(negedge clk);
    pre_idx = 6'(i);
    pre_dat = d;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cyc"}, {31'd0, bus.cyc_o}, 0);
    chk({tag, "_stb"}, {31'd0, bus.stb_o}, 0);
    chk({tag, "_we"}, {31'd0, bus.we_o}, 0);
    chk({tag, "_adr"}, bus.adr_o, 0);
    chk({tag, "_dat"}, bus.dat_o, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_errcnt"}, {16'd0, error_count}, 0);
    chk({tag, "_tmo"}, {31'd0, timeout}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b1;

    // zero-wait interleaved run, seed 0, exact cycle count
    run(MODE_INTERLEAVE, 32'h0, 0, -1, "il0");

    // block mode write-all then read-all
    run(MODE_BLOCK, 32'hA5A5A5A5, 2, -1, "block");

    // read check against a corrupted word 5
    run(MODE_WRITE, 32'h12345678, 1, -1, "fill");
    poke(5, 32'hDEADBEEF);
    run(MODE_READ, 32'h12345678, 1, -1, "corrupt");

    // err_i with ack_i on the third write
    run(MODE_WRITE, $urandom, 1, 2, "err3");

    // slave never terminates: bounded abort
    hang = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    mode = MODE_WRITE;
    seed = $urandom;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    n = 0;
    t = 0;
    while (bus.cyc_o && t < 100) begin
      n++;
      @(posedge clk);
      #1;
      t++;
    end
    chk("tmo_cyc_len", n, TMO);
    chk("tmo_flag", {31'd0, timeout}, 1);
    chk("tmo_done", {31'd0, done}, 1);
    chk("tmo_busy", {31'd0, busy}, 0);
    chk("tmo_stb", {31'd0, bus.stb_o}, 0);
    chk("tmo_errcnt", {16'd0, error_count}, 0);
    hang = 1'b0;
    mon_en = 1'b1;
    run(MODE_INTERLEAVE, $urandom, 1, -1, "after_tmo");

    // reset during the wait of word 7
    mon_en = 1'b0;
    waits_max = 0;
    @(negedge clk);
    mode = MODE_INTERLEAVE;
    seed = $urandom;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (!(bus.cyc_o && bus.adr_o == w_adr(7)) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach_w7", {31'd0, t < 200}, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    run(MODE_INTERLEAVE, $urandom, 0, -1, "restart");

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      logic [1:0] rm;
      int er;
      rm = 2'($urandom_range(3, 0));
      er = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0)) : -1;
      run(rm, $urandom, int'($urandom_range(2, 0)), er, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_traffic_master.md
Name: wb_traffic_master

Overview:
Parametrised Wishbone classic-cycle traffic generator and checker, the successor to the fixed 16-word write/read-back test master. It generates an arithmetic data pattern over a configurable address window and runs one of four modes. It records mismatches and bus errors in a counter instead of halting simulation, and aborts on a bounded ack timeout. It sits in interconnect test systems as a bus master driving one slave port or a crossbar port.

Parameters:
DATA_WIDTH, 32, width of dat_o/dat_i
ADDR_WIDTH, 32, width of adr_o
WORD_COUNT, 16, words per run; legal range 2..65536
ADDR_BASE, 0, address of word 0
ADDR_STRIDE, 1, address increment per word
PATTERN_STEP, 32'h11111111, data increment per word (truncated to DATA_WIDTH)
TIMEOUT_CYCLES, 255, maximum cycles to wait for ack/err before abort; must be at least 1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
start  in  1  run request, sampled only in IDLE
mode  in  2  0=interleaved write/read-back, 1=write-all then read-all, 2=write-only, 3=read-only check; sampled with start
seed  in  DATA_WIDTH  pattern value of word 0; sampled with start
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  write enable
adr_o  out  ADDR_WIDTH  address
dat_o  out  DATA_WIDTH  write data
dat_i  in  DATA_WIDTH  read data
ack_i  in  1  termination, normal
err_i  in  1  termination, error
busy  out  1  run in progress
done  out  1  run finished; level
error_count  out  16  mismatches plus err_i terminations, saturating at 16'hFFFF
timeout  out  1  last run aborted on timeout; level

Behaviour:
- Reset (rst==0 at a clock edge): all outputs 0, state IDLE, index 0, timeout counter 0. Reset mid-transaction drops cyc_o/stb_o at that same edge.
- Word i: address = ADDR_BASE + i*ADDR_STRIDE, data = seed + i*PATTERN_STEP. Both are mod 2^width.
- States: IDLE, REQ, WAIT, GAP.
- IDLE: when start==1, latch mode and seed, clear done, timeout and error_count, set busy, set index 0, go to REQ. start while busy is ignored.
- REQ (one cycle): drive adr_o and dat_o. Assert cyc_o, stb_o and we_o (per phase) so they are valid at the next edge. Go to WAIT.
- Request timing: cyc_o/stb_o assert exactly one cycle after the start-accept edge and stay stable until termination.
- WAIT: a termination is ack_i|err_i sampled while stb_o==1. On termination, drop cyc_o/stb_o/we_o at that edge and go to GAP.
- Error counting in WAIT: err_i increments error_count; err_i has priority when ack_i and err_i are both high. A read with ack_i and dat_i != expected also increments error_count.
- GAP: exactly one idle cycle between transactions. Then either advance the phase/index and go to REQ, or finish.
- Mode 0: W0,R0,W1,R1,… Mode 1: W0..W(N-1), then R0..R(N-1). Mode 2: writes only. Mode 3: reads only, compared against the pattern.
- Finish: after the last transaction's GAP, busy=0, done=1, adr_o=0, go to IDLE. done holds until the next accepted start.
- Timeout: a counter runs in WAIT and is cleared on REQ. If TIMEOUT_CYCLES elapse with no termination: drop cyc/stb/we, set timeout=1 and done=1, clear busy, go to IDLE. error_count is not incremented on timeout.
- dat_o holds its last value outside writes. we_o is 0 whenever cyc_o is 0.

Decomposition:
- Package wb_traffic_pkg holds: state encoding; mode constants MODE_INTERLEAVE, MODE_BLOCK, MODE_WRITE, MODE_READ; ERRCNT_W=16.
- Sub-module wb_pattern_gen is natural. It holds registered incremental address and data generators: load on start, step on advance, no multiplier.

Test Plan:
- Zero-wait loopback RAM, defaults, mode 0, seed 0 -> 32 transactions; data written 0x00000000..0xFFFFFFFF step 0x11111111; error_count 0; done=1 at cycle 32*3+1 after start; timeout 0.
- Mode 1, WORD_COUNT=4, ADDR_BASE=0x100, ADDR_STRIDE=4, seed 0xA5A5A5A5 -> writes to 0x100,0x104,0x108,0x10C, then reads in the same order; error_count 0.
- Mode 3 against a RAM preloaded with a corrupted word 5 (value 0xDEADBEEF) -> exactly one mismatch; error_count 1; all 16 reads complete.
- Slave asserts err_i together with ack_i on the 3rd write in mode 2 -> error_count 1; run continues to done.
- Slave never acks, TIMEOUT_CYCLES=10 -> cyc_o high exactly 10 WAIT cycles then drops; timeout=1; done=1; busy=0; a following start clears timeout.
- rst low during WAIT of word 7 -> all outputs 0 after that edge; a fresh start restarts at word 0.
